// File: rtl/uart_recv_if.sv
// Byte-side bus of the UART receiver: received byte plus the one-cycle
// status strobes. The receiver drives the master modport and the
// command/datapath logic consumes it through the slave modport.
interface uart_recv_if;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       parity_err;

   modport master (output data, valid, frame_err, parity_err);
   modport slave  (input  data, valid, frame_err, parity_err);
endinterface

// File: rtl/uart_recv.sv
// UART receiver: serial frames on din -> parallel bytes on the bus interface.
// Default build is 8N1. Defining UART_PARITY_EN selects 8E1 (even parity bit
// after bit 7) and enables the parity_err strobe; otherwise parity_err is 0.
// Every decision is taken on the synchronised line sample at mid-bit.
module uart_recv #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 9600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   uart_recv_if.master bus
);
   localparam int          BAUD_DIV  = CLOCK_FREQ / BAUD_RATE;
   localparam int          HALF_DIV  = BAUD_DIV / 2;
   localparam logic [13:0] BAUD_LAST = 14'(BAUD_DIV - 1);
   localparam logic [13:0] HALF_LAST = 14'(HALF_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
`ifdef UART_PARITY_EN
      S_PARITY    = 3'd3,
`endif
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   state_t      r_state;
   logic        r_sync1;
   logic        r_sync2;
   logic        r_din_prev;
   logic [1:0]  r_warm;
   logic [13:0] r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_frame_err;
   logic        w_din_s;
   logic        w_fall;

   assign w_din_s = r_sync2;
   // r_din_prev only carries real line history, so the reset value of the
   // synchroniser can never look like a start edge on a line held low.
   assign w_fall  = r_din_prev & ~w_din_s;

`ifdef UART_PARITY_EN
   logic r_par_bit;
   logic r_parity_err;
   logic w_par_bad;

   // Even parity: XOR of the data bits equals the transmitted parity bit.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

   assign w_par_bad      = even_parity(r_shift) ^ r_par_bit;
   assign bus.parity_err = r_parity_err;
`else
   assign bus.parity_err = 1'b0;
`endif

   assign bus.data      = r_data;
   assign bus.valid     = r_valid;
   assign bus.frame_err = r_frame_err;

   // Two-flop synchroniser plus edge-detect history, armed once real samples arrive.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_din_prev <= 1'b0;
         r_warm     <= 2'd0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         if (r_warm == 2'd2) begin
            r_din_prev <= w_din_s;
         end else begin
            r_din_prev <= 1'b0;
            r_warm     <= r_warm + 2'd1;
         end
      end
   end

   // Frame FSM with baud counter, shift register and registered output strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 14'd0;
         r_bit       <= 3'd0;
         r_shift     <= 8'h00;
         r_data      <= 8'h00;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               r_cnt <= 14'd0;
               r_bit <= 3'd0;
               if (w_fall) begin
                  r_state <= S_START;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_START: begin
               if (r_cnt == HALF_LAST) begin
                  r_cnt <= 14'd0;
                  // Line back high at mid start bit means it was only a glitch.
                  if (!w_din_s) begin
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 14'd1;
               end
            end
            S_DATA: begin
               if (r_cnt == BAUD_LAST) begin
                  r_cnt   <= 14'd0;
                  r_shift <= {w_din_s, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_state <= S_DATA;
                  end
               end else begin
                  r_cnt <= r_cnt + 14'd1;
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
               if (r_cnt == BAUD_LAST) begin
                  r_cnt     <= 14'd0;
                  r_par_bit <= w_din_s;
                  r_state   <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 14'd1;
               end
            end
`endif
            S_STOP: begin
               if (r_cnt == BAUD_LAST) begin
                  r_cnt <= 14'd0;
                  if (w_din_s) begin
`ifdef UART_PARITY_EN
                     if (w_par_bad) begin
                        r_parity_err <= 1'b1;
                     end else begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end
`else
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
`endif
                     r_state <= S_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
                     r_parity_err <= w_par_bad;
`endif
                     r_state <= S_WAIT_HIGH;
                  end
               end else begin
                  r_cnt <= r_cnt + 14'd1;
               end
            end
            S_WAIT_HIGH: begin
               r_cnt <= 14'd0;
               if (w_din_s) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_WAIT_HIGH;
               end
            end
            default: begin
               r_cnt   <= 14'd0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
